// File: rtl/noise_mem_ctrl_if.sv
// noise_mem_ctrl_if: signal bundle between noise_mem_ctrl and its environment.
// Host write port : host_write, host_address, host_writedata, host_byteenable -> host_waitrequest
// Stream control  : stream_start, stream_stop, cfg_len -> busy
// Noise output    : noise_valid, noise_data, noise_wrap, noise_ready (consumer back-pressure)
// Memory port     : mem_address, mem_chipselect, mem_write, mem_writedata, mem_byteenable,
//                   mem_clken -> mem_readdata (valid one cycle after a read issue)
// master drives the requests and the memory read data; slave is the controller.
interface noise_mem_ctrl_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32,
    parameter int BE_W   = 4
);
    logic              host_write;
    logic [ADDR_W-1:0] host_address;
    logic [DATA_W-1:0] host_writedata;
    logic [BE_W-1:0]   host_byteenable;
    logic              host_waitrequest;
    logic              stream_start;
    logic              stream_stop;
    logic [ADDR_W:0]   cfg_len;
    logic              noise_valid;
    logic [DATA_W-1:0] noise_data;
    logic              noise_ready;
    logic              noise_wrap;
    logic              busy;
    logic [ADDR_W-1:0] mem_address;
    logic              mem_chipselect;
    logic              mem_write;
    logic [DATA_W-1:0] mem_writedata;
    logic [BE_W-1:0]   mem_byteenable;
    logic              mem_clken;
    logic [DATA_W-1:0] mem_readdata;

    modport master (
        output host_write, host_address, host_writedata, host_byteenable,
        output stream_start, stream_stop, cfg_len, noise_ready, mem_readdata,
        input  host_waitrequest, noise_valid, noise_data, noise_wrap, busy,
        input  mem_address, mem_chipselect, mem_write, mem_writedata, mem_byteenable, mem_clken
    );

    modport slave (
        input  host_write, host_address, host_writedata, host_byteenable,
        input  stream_start, stream_stop, cfg_len, noise_ready, mem_readdata,
        output host_waitrequest, noise_valid, noise_data, noise_wrap, busy,
        output mem_address, mem_chipselect, mem_write, mem_writedata, mem_byteenable, mem_clken
    );
endinterface

// File: rtl/noise_mem_ctrl.sv
// noise_mem_ctrl: shares one on-chip memory port between host writes and a circular
// noise-table reader that streams samples through a 2-entry FIFO.
// Ports: clk (rising edge), reset (sync, active-high), bus (noise_mem_ctrl_if.slave):
//   host write port with waitrequest, stream start/stop/length, valid/ready noise
//   output with wrap pulse and busy flag, and the memory port driven combinationally.
module noise_mem_ctrl #(
    parameter int DEPTH      = 128,
    parameter int ADDR_W     = 7,
    parameter int DATA_W     = 32,
    parameter int BE_W       = 4,
    parameter int STARVE_MAX = 4
) (
    input logic             clk,
    input logic             reset,
    noise_mem_ctrl_if.slave bus
);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W + 1)'(DEPTH);
    localparam logic [SW-1:0] S_MAX = SW'(STARVE_MAX);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t            r_state, w_next;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_len;
    logic [SW-1:0]     r_starve;
    logic              r_inflight;
    logic [DATA_W-1:0] r_fifo [2];
    logic              r_head, r_tail;
    logic [1:0]        r_cnt;
    logic              w_pop, w_rd_req, w_rd_gnt, w_host_gnt, w_last, w_start, w_flush;
    logic [1:0]        w_occ;
    logic [ADDR_W:0]   w_cfg_len;

    // Occupancy counts the head as gone when it is popped this cycle, so a steady
    // consumer sees one issue per cycle while the FIFO still cannot overflow.
    assign w_pop      = (r_cnt != 2'd0) & bus.noise_ready;
    assign w_occ      = r_cnt - {1'b0, w_pop};
    assign w_rd_req   = (r_state == RUN) && ((w_occ + {1'b0, r_inflight}) < 2'd2);
    // Grants are suppressed during reset so the memory port and waitrequest idle.
    assign w_rd_gnt   = !reset && w_rd_req && (!bus.host_write || r_starve == S_MAX);
    assign w_host_gnt = !reset && bus.host_write && !w_rd_gnt;
    assign w_last     = {1'b0, r_rd_ptr} == r_len - 1'b1;
    assign w_cfg_len  = (bus.cfg_len == '0 || bus.cfg_len > LEN_MAX) ? LEN_MAX : bus.cfg_len;
    assign w_start    = (r_state == IDLE) && (w_next == RUN);
    assign w_flush    = (r_state == DRAIN) && (w_next == IDLE);

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = (bus.stream_start && !bus.stream_stop) ? RUN : IDLE;
            RUN:     w_next = bus.stream_stop ? DRAIN : RUN;
            DRAIN:   w_next = r_inflight ? DRAIN : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        bus.mem_clken        = 1'b1;
        bus.mem_chipselect   = w_host_gnt | w_rd_gnt;
        bus.mem_write        = w_host_gnt;
        bus.mem_address      = w_host_gnt ? bus.host_address : r_rd_ptr;
        bus.mem_writedata    = w_host_gnt ? bus.host_writedata : '0;
        bus.mem_byteenable   = w_host_gnt ? bus.host_byteenable : {BE_W{1'b1}};
        bus.host_waitrequest = !w_host_gnt;
        bus.noise_wrap       = w_rd_gnt & w_last;
        bus.noise_valid      = r_cnt != 2'd0;
        bus.noise_data       = r_fifo[r_head];
        bus.busy             = r_state != IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_ptr   <= '0;
            r_len      <= LEN_MAX;
            r_starve   <= '0;
            r_inflight <= 1'b0;
            r_head     <= 1'b0;
            r_tail     <= 1'b0;
            r_cnt      <= 2'd0;
        end else begin
            r_inflight <= w_rd_gnt;
            if (w_start) begin
                r_rd_ptr <= '0;
                r_len    <= w_cfg_len;
            end else if (w_rd_gnt) begin
                r_rd_ptr <= w_last ? '0 : r_rd_ptr + 1'b1;
            end
            if (w_rd_gnt)
                r_starve <= '0;
            else if (w_host_gnt && w_rd_req && r_starve != S_MAX)
                r_starve <= r_starve + 1'b1;
            if (w_flush) begin
                r_head <= 1'b0;
                r_tail <= 1'b0;
                r_cnt  <= 2'd0;
            end else begin
                if (r_inflight)
                    r_tail <= ~r_tail;
                if (w_pop)
                    r_head <= ~r_head;
                r_cnt <= r_cnt + {1'b0, r_inflight} - {1'b0, w_pop};
            end
        end
    end

    // Read data lands the cycle after issue; a flush cycle may overwrite a slot harmlessly.
    always_ff @(posedge clk) begin
        if (r_inflight)
            r_fifo[r_tail] <= bus.mem_readdata;
    end
endmodule

// File: doc/noise_mem_ctrl.md
NOISE_MEM_CTRL -- requirements
Module: noise_mem_ctrl

Interface
REQ-001 Parameters SHALL be: DEPTH, 128, noise table entries; ADDR_W, 7, memory address width; DATA_W, 32, sample width; BE_W, 4, byte-enable width (DATA_W/8); STARVE_MAX, 4, host wins before reader is forced.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  clock, all logic on rising edge.
REQ-004 reset  in  1  synchronous active-high reset.
REQ-005 host_write  in  1  host write request, held until accepted.
REQ-006 host_address  in  ADDR_W  host write address.
REQ-007 host_writedata  in  DATA_W  host write data.
REQ-008 host_byteenable  in  BE_W  host byte lanes.
REQ-009 host_waitrequest  out  1  high = host write not accepted this cycle.
REQ-010 stream_start  in  1  pulse: begin circular noise readout.
REQ-011 stream_stop  in  1  pulse: end readout.
REQ-012 cfg_len  in  ADDR_W+1  table length latched at start; 0 or >DEPTH means DEPTH.
REQ-013 noise_valid  out  1  noise_data valid.
REQ-014 noise_data  out  DATA_W  noise sample.
REQ-015 noise_ready  in  1  consumer accepts when valid&ready.
REQ-016 noise_wrap  out  1  one-cycle pulse when read pointer wraps to 0.
REQ-017 busy  out  1  high in RUN or DRAIN.
REQ-018 mem_address, mem_chipselect, mem_write, mem_writedata, mem_byteenable, mem_clken  out  ADDR_W/1/1/DATA_W/BE_W/1  on-chip memory port.
REQ-019 mem_readdata  in  DATA_W  memory read data, valid exactly 1 cycle after a read issue.

Function
REQ-020 FSM states SHALL be IDLE, RUN, DRAIN; IDLE->RUN on stream_start; RUN->DRAIN on stream_stop; DRAIN->IDLE when no read in flight; stream_start outside IDLE ignored; start and stop in same IDLE cycle: stay IDLE.
REQ-021 On IDLE->RUN, rd_ptr SHALL clear to 0 and cfg_len SHALL be latched as len.
REQ-022 Reader request SHALL be asserted in RUN only when FIFO occupancy + in-flight reads < 2.
REQ-023 Arbitration: host wins when both request unless starve_cnt == STARVE_MAX, then reader wins.
REQ-024 starve_cnt SHALL increment when host wins while reader requests, clear when reader is granted, saturate at STARVE_MAX.
REQ-025 host_waitrequest SHALL be low exactly in the cycle the host write is granted, high otherwise (including while host_write low).
REQ-026 Host grant: mem_chipselect=1, mem_write=1, mem_address=host_address, mem_writedata=host_writedata, mem_byteenable=host_byteenable, same cycle (combinational).
REQ-027 Reader grant: mem_chipselect=1, mem_write=0, mem_address=rd_ptr, mem_byteenable all ones; rd_ptr advances, wraps to 0 after len-1 and noise_wrap pulses in that issue cycle.
REQ-028 No grant: mem_chipselect=0, mem_write=0; mem_clken SHALL be constant 1.
REQ-029 Read data SHALL be captured into a 2-entry FIFO the cycle after issue; noise_valid = FIFO non-empty; noise_data = FIFO head; pop on valid&ready; simultaneous push and pop legal.
REQ-030 FIFO SHALL never overflow; issue throttling per REQ-022 guarantees it.
REQ-031 In DRAIN no new reads; in-flight data still enters FIFO; on DRAIN->IDLE FIFO flushed, noise_valid low in IDLE.
REQ-032 Host writes SHALL be serviced in every state; host alone never waits more than 0 cycles.
REQ-033 Sustained throughput with noise_ready=1 and no host traffic: one sample per cycle after 2-cycle start latency (first noise_valid 2 cycles after stream_start).

Reset
REQ-034 On reset: state IDLE, rd_ptr 0, starve_cnt 0, FIFO empty, in-flight cleared; noise_valid 0, noise_wrap 0, busy 0, mem_chipselect 0, mem_write 0, host_waitrequest 1.
REQ-035 Reset mid-RUN or mid-DRAIN SHALL discard in-flight read data; mem_readdata after reset ignored.

Verification
REQ-036 Host writes 0x1000+i to addresses 0..127, no streaming -> each write accepted same cycle, host_waitrequest low on each write cycle.
REQ-037 Table loaded, cfg_len=4, start, noise_ready=1 -> noise_data 0x1000,0x1001,0x1002,0x1003,0x1000...; noise_wrap each 4th issue; first valid 2 cycles after start.
REQ-038 Streaming with continuous host_write -> reader granted exactly once every STARVE_MAX+1=5 cycles; no sample lost or reordered.
REQ-039 noise_ready held low 10 cycles during RUN -> FIFO holds 2 samples, no further reads issued, sequence resumes intact on ready.
REQ-040 stream_stop with one read in flight -> DRAIN 1 cycle, then IDLE, busy low, noise_valid low.
REQ-041 reset asserted mid-RUN -> next cycle all outputs at REQ-034 values; subsequent start restarts at address 0.
